// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared game definitions for the enemy spawn scheduler: FSM state encoding,
// default sizing and counter widths.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SPAWN,
        GAP,
        CLEAR
    } spawn_state_e;

    localparam int N_ENEMY_DEF   = 4;
    localparam int N_SPAWN_DEF   = 3;
    localparam int SPAWN_GAP_DEF = 1000000;
    localparam int ENEMY_CNT_W   = 6;
    localparam int POINT_W       = 2;

endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// Bundle between the spawn scheduler and the game logic around it.
// freeze_i exists only when SPAWN_FREEZE_EN is defined.
interface enemy_spawn_scheduler_if
    import game_pkg::*;
#(
    parameter int N_ENEMY = N_ENEMY_DEF,
    parameter int N_SPAWN = N_SPAWN_DEF
);
    logic                   level_start_i;
    logic [ENEMY_CNT_W-1:0] enemy_reserve_i;
    logic [N_ENEMY-1:0]     enemy_die_i;
    logic [N_SPAWN-1:0]     spawn_point_busy_i;
`ifdef SPAWN_FREEZE_EN
    logic                   freeze_i;
`endif
    logic [N_ENEMY-1:0]     spawn_valid_o;
    logic [POINT_W-1:0]     spawn_point_o;
    logic [N_ENEMY-1:0]     enemy_alive_o;
    logic [ENEMY_CNT_W-1:0] enemy_left_o;
    logic                   level_clear_o;

    // Game side: drives level control, deaths and tile occupancy.
    modport master (
        output level_start_i, enemy_reserve_i, enemy_die_i, spawn_point_busy_i,
`ifdef SPAWN_FREEZE_EN
        output freeze_i,
`endif
        input  spawn_valid_o, spawn_point_o, enemy_alive_o, enemy_left_o, level_clear_o
    );

    modport slave (
        input  level_start_i, enemy_reserve_i, enemy_die_i, spawn_point_busy_i,
`ifdef SPAWN_FREEZE_EN
        input  freeze_i,
`endif
        output spawn_valid_o, spawn_point_o, enemy_alive_o, enemy_left_o, level_clear_o
    );

endinterface

// File: rtl/enemy_spawn_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: maps the level reserve onto enemy slots with a
// minimum gap between spawns. Optional freeze input under SPAWN_FREEZE_EN.
module enemy_spawn_scheduler
    import game_pkg::*;
#(
    parameter int N_ENEMY   = N_ENEMY_DEF,
    parameter int N_SPAWN   = N_SPAWN_DEF,
    parameter int SPAWN_GAP = SPAWN_GAP_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_all_i,
    enemy_spawn_scheduler_if.slave  bus
);

    localparam int SLOT_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam int CNT_W  = $clog2(SPAWN_GAP) + 1;

    function automatic logic [ENEMY_CNT_W-1:0] popcount(input logic [N_ENEMY-1:0] v);
        logic [ENEMY_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_ENEMY; i++) c = c + ENEMY_CNT_W'(v[i]);
        return c;
    endfunction

    spawn_state_e           state;
    logic [ENEMY_CNT_W-1:0] reserve;
    logic [N_ENEMY-1:0]     alive;
    logic [POINT_W-1:0]     rr;
    logic [CNT_W-1:0]       cnt;
    logic [N_ENEMY-1:0]     spawn_valid;
    logic [POINT_W-1:0]     spawn_point;
    logic [ENEMY_CNT_W-1:0] enemy_left;
    logic                   level_clear;

    logic [SLOT_W-1:0]      slot_sel;
    logic [POINT_W-1:0]     point_sel;

    logic                   freeze;
    logic [SLOT_W-1:0]      free_slot;
    logic                   slot_found;
    logic [N_SPAWN-1:0]     point_free;
    logic [POINT_W-1:0]     pick_idx;
    logic                   pick_found;
    logic                   gap_done;
    logic [N_ENEMY-1:0]     alive_after_die;
    logic [N_ENEMY-1:0]     sel_mask;
    logic [N_ENEMY-1:0]     spawn_mask;
    logic [POINT_W-1:0]     rr_next;

`ifdef SPAWN_FREEZE_EN
    assign freeze = bus.freeze_i;
`else
    assign freeze = 1'b0;
`endif

    // Lowest-index free slot.
    always_comb begin
        free_slot  = '0;
        slot_found = 1'b0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (!alive[i]) begin
                free_slot  = SLOT_W'(i);
                slot_found = 1'b1;
            end
        end
    end

    assign point_free = ~bus.spawn_point_busy_i;

    rr_pick #(
        .N     (N_SPAWN),
        .IDX_W (POINT_W)
    ) u_pick (
        .req   (point_free),
        .ptr   (rr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // GAP lasts SPAWN_GAP-2 cycles so SPAWN->GAP..->SELECT->SPAWN spans SPAWN_GAP.
    assign gap_done        = (int'(cnt) + 1) >= (SPAWN_GAP - 2);
    assign alive_after_die = alive & ~bus.enemy_die_i;
    assign sel_mask        = N_ENEMY'(1) << free_slot;
    assign spawn_mask      = N_ENEMY'(1) << slot_sel;
    assign rr_next         = (point_sel == POINT_W'(N_SPAWN - 1)) ? '0 : point_sel + POINT_W'(1);

    always_ff @(posedge clk_i or posedge reset_all_i) begin
        if (reset_all_i) begin
            state       <= IDLE;
            reserve     <= '0;
            alive       <= '0;
            rr          <= '0;
            cnt         <= '0;
            spawn_valid <= '0;
            spawn_point <= '0;
            enemy_left  <= '0;
            level_clear <= 1'b0;
        end else begin
            spawn_valid <= '0;
            spawn_point <= '0;
            enemy_left  <= reserve + popcount(alive);
            alive       <= alive_after_die;
            if (bus.level_start_i) begin
                reserve     <= bus.enemy_reserve_i;
                alive       <= '0;
                rr          <= '0;
                cnt         <= '0;
                level_clear <= 1'b0;
                state       <= SELECT;
            end else begin
                case (state)
                    SELECT: begin
                        if (reserve == '0 && alive == '0) begin
                            level_clear <= 1'b1;
                            state       <= CLEAR;
                        end else if (reserve != '0 && !freeze && slot_found && pick_found) begin
                            spawn_valid <= sel_mask;
                            spawn_point <= pick_idx;
                            state       <= SPAWN;
                        end
                    end
                    SPAWN: begin
                        alive <= alive_after_die | spawn_mask;
                        if (reserve != '0) reserve <= reserve - ENEMY_CNT_W'(1);
                        rr    <= rr_next;
                        cnt   <= '0;
                        state <= GAP;
                    end
                    GAP: begin
                        if (!freeze) begin
                            cnt <= cnt + CNT_W'(1);
                            if (gap_done) state <= SELECT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Choice made in SELECT is held for SPAWN; busy is not resampled.
    always_ff @(posedge clk_i) begin
        if (state == SELECT) begin
            slot_sel  <= free_slot;
            point_sel <= pick_idx;
        end
    end

    assign bus.spawn_valid_o = spawn_valid;
    assign bus.spawn_point_o = spawn_point;
    assign bus.enemy_alive_o = alive;
    assign bus.enemy_left_o  = enemy_left;
    assign bus.level_clear_o = level_clear;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler with SPAWN_GAP=4, 4 slots, 3 points.
module tb_enemy_spawn_scheduler;

    logic clk = 1'b0;
    logic reset_all;
    always #5 clk = ~clk;

    enemy_spawn_scheduler_if #(.N_ENEMY(4), .N_SPAWN(3)) bus ();

    enemy_spawn_scheduler #(
        .N_ENEMY   (4),
        .N_SPAWN   (3),
        .SPAWN_GAP (4)
    ) dut (
        .clk_i       (clk),
        .reset_all_i (reset_all),
        .bus         (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [5:0] r);
        bus.level_start_i   = 1'b1;
        bus.enemy_reserve_i = r;
        tick();
        bus.level_start_i   = 1'b0;
    endtask

    task automatic wait_spawn(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.spawn_valid_o == '0 && n < limit);
    endtask

    task automatic test_reset();
        int n;
        int pulses;
        reset_all = 1'b1;
        tick();
        tick();
        total++; if (bus.spawn_valid_o !== 4'h0) begin bad++; $display("FAIL rst_valid got %0h want 0", bus.spawn_valid_o); end
        total++; if (bus.spawn_point_o !== 2'd0) begin bad++; $display("FAIL rst_point got %0h want 0", bus.spawn_point_o); end
        total++; if (bus.enemy_alive_o !== 4'h0) begin bad++; $display("FAIL rst_alive got %0h want 0", bus.enemy_alive_o); end
        total++; if (bus.enemy_left_o !== 6'd0) begin bad++; $display("FAIL rst_left got %0d want 0", bus.enemy_left_o); end
        total++; if (bus.level_clear_o !== 1'b0) begin bad++; $display("FAIL rst_clear got %0b want 0", bus.level_clear_o); end
        reset_all = 1'b0;
        tick();
        start(6'd5);
        wait_spawn(8, n);
        total++; if (n !== 1) begin bad++; $display("FAIL rst_first_latency got %0d want 1", n); end
        tick();
        total++; if (bus.enemy_left_o !== 6'd5) begin bad++; $display("FAIL rst_left_pre got %0d want 5", bus.enemy_left_o); end
        reset_all = 1'b1;
        tick();
        total++; if (bus.enemy_alive_o !== 4'h0) begin bad++; $display("FAIL rst_mid_alive got %0h want 0", bus.enemy_alive_o); end
        total++; if (bus.enemy_left_o !== 6'd0) begin bad++; $display("FAIL rst_mid_left got %0d want 0", bus.enemy_left_o); end
        reset_all = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.spawn_valid_o != '0) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rst_idle_pulses got %0d want 0", pulses); end
        total++; if (bus.enemy_left_o !== 6'd0) begin bad++; $display("FAIL rst_idle_left got %0d want 0", bus.enemy_left_o); end
    endtask

    task automatic test_fill();
        logic [3:0] exp_slot [4];
        logic [1:0] exp_pt   [4];
        int         exp_gap  [4];
        int n;
        int pulses;
        exp_slot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_pt   = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_gap  = '{1, 4, 4, 4};
        start(6'd6);
        for (int i = 0; i < 4; i++) begin
            wait_spawn(10, n);
            total++; if (n !== exp_gap[i]) begin bad++; $display("FAIL fill_gap%0d got %0d want %0d", i, n, exp_gap[i]); end
            total++; if (bus.spawn_valid_o !== exp_slot[i]) begin bad++; $display("FAIL fill_slot%0d got %0h want %0h", i, bus.spawn_valid_o, exp_slot[i]); end
            total++; if (bus.spawn_point_o !== exp_pt[i]) begin bad++; $display("FAIL fill_point%0d got %0d want %0d", i, bus.spawn_point_o, exp_pt[i]); end
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.spawn_valid_o != '0) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL fill_stall got %0d want 0", pulses); end
        total++; if (bus.enemy_left_o !== 6'd6) begin bad++; $display("FAIL fill_left got %0d want 6", bus.enemy_left_o); end
        total++; if (bus.enemy_alive_o !== 4'hf) begin bad++; $display("FAIL fill_alive got %0h want f", bus.enemy_alive_o); end
    endtask

    task automatic test_die_respawn();
        bus.enemy_die_i = 4'b0100;
        tick();
        bus.enemy_die_i = 4'b0000;
        total++; if (bus.enemy_alive_o !== 4'b1011) begin bad++; $display("FAIL die_alive got %0h want b", bus.enemy_alive_o); end
        total++; if (bus.enemy_left_o !== 6'd6) begin bad++; $display("FAIL die_left_lag got %0d want 6", bus.enemy_left_o); end
        tick();
        total++; if (bus.spawn_valid_o !== 4'b0100) begin bad++; $display("FAIL die_slot got %0h want 4", bus.spawn_valid_o); end
        total++; if (bus.spawn_point_o !== 2'd1) begin bad++; $display("FAIL die_point got %0d want 1", bus.spawn_point_o); end
        total++; if (bus.enemy_left_o !== 6'd5) begin bad++; $display("FAIL die_left got %0d want 5", bus.enemy_left_o); end
    endtask

    task automatic test_busy();
        int n;
        int pulses;
        bus.spawn_point_busy_i = 3'b011;
        start(6'd3);
        tick();
        total++; if (bus.spawn_valid_o !== 4'b0001) begin bad++; $display("FAIL busy_slot got %0h want 1", bus.spawn_valid_o); end
        total++; if (bus.spawn_point_o !== 2'd2) begin bad++; $display("FAIL busy_point got %0d want 2", bus.spawn_point_o); end
        bus.spawn_point_busy_i = 3'b111;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.spawn_valid_o != '0) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL busy_all got %0d pulses want 0", pulses); end
        bus.spawn_point_busy_i = 3'b110;
        wait_spawn(2, n);
        total++; if (bus.spawn_valid_o !== 4'b0010) begin bad++; $display("FAIL busy_free_slot got %0h want 2", bus.spawn_valid_o); end
        total++; if (bus.spawn_point_o !== 2'd0) begin bad++; $display("FAIL busy_free_point got %0d want 0", bus.spawn_point_o); end
        total++; if (n !== 1) begin bad++; $display("FAIL busy_free_lat got %0d want 1", n); end
        bus.spawn_point_busy_i = 3'b000;
    endtask

    task automatic test_clear();
        int n;
        int pulses;
        start(6'd1);
        wait_spawn(8, n);
        total++; if (bus.spawn_valid_o !== 4'b0001) begin bad++; $display("FAIL clr_slot got %0h want 1", bus.spawn_valid_o); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (bus.level_clear_o !== 1'b0) begin bad++; $display("FAIL clr_early got %0b want 0", bus.level_clear_o); end
        bus.enemy_die_i = 4'b0001;
        tick();
        bus.enemy_die_i = 4'b0000;
        total++; if (bus.enemy_alive_o !== 4'h0) begin bad++; $display("FAIL clr_alive got %0h want 0", bus.enemy_alive_o); end
        tick();
        total++; if (bus.level_clear_o !== 1'b1) begin bad++; $display("FAIL clr_rise got %0b want 1", bus.level_clear_o); end
        total++; if (bus.enemy_left_o !== 6'd0) begin bad++; $display("FAIL clr_left got %0d want 0", bus.enemy_left_o); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.spawn_valid_o != '0) pulses++;
        end
        total++; if (bus.level_clear_o !== 1'b1) begin bad++; $display("FAIL clr_hold got %0b want 1", bus.level_clear_o); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL clr_pulses got %0d want 0", pulses); end
        start(6'd2);
        total++; if (bus.level_clear_o !== 1'b0) begin bad++; $display("FAIL clr_restart got %0b want 0", bus.level_clear_o); end
        start(6'd0);
        total++; if (bus.level_clear_o !== 1'b0) begin bad++; $display("FAIL clr_zero_t1 got %0b want 0", bus.level_clear_o); end
        tick();
        total++; if (bus.level_clear_o !== 1'b1) begin bad++; $display("FAIL clr_zero_t2 got %0b want 1", bus.level_clear_o); end
    endtask

    task automatic test_double_die();
        int n;
        int pulses;
        start(6'd6);
        wait_spawn(8, n);
        wait_spawn(8, n);
        total++; if (n !== 4) begin bad++; $display("FAIL dd_gap2 got %0d want 4", n); end
        tick();
        bus.enemy_die_i = 4'b0011;
        tick();
        bus.enemy_die_i = 4'b0000;
        total++; if (bus.enemy_alive_o !== 4'h0) begin bad++; $display("FAIL dd_alive got %0h want 0", bus.enemy_alive_o); end
        tick();
        total++; if (bus.enemy_left_o !== 6'd4) begin bad++; $display("FAIL dd_left got %0d want 4", bus.enemy_left_o); end
        wait_spawn(8, n);
        total++; if (n + 3 !== 4) begin bad++; $display("FAIL dd_gap3 got %0d want 4", n + 3); end
        total++; if (bus.spawn_valid_o !== 4'b0001) begin bad++; $display("FAIL dd_slot got %0h want 1", bus.spawn_valid_o); end
        total++; if (bus.spawn_point_o !== 2'd2) begin bad++; $display("FAIL dd_point got %0d want 2", bus.spawn_point_o); end
`ifdef SPAWN_FREEZE_EN
        tick();
        bus.freeze_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.spawn_valid_o != '0) pulses++;
        end
        bus.freeze_i = 1'b0;
        total++; if (pulses !== 0) begin bad++; $display("FAIL frz_pulses got %0d want 0", pulses); end
        wait_spawn(10, n);
        total++; if (n + 11 !== 14) begin bad++; $display("FAIL frz_gap got %0d want 14", n + 11); end
`else
        pulses = 0;
`endif
    endtask

    initial begin
        reset_all              = 1'b1;
        bus.level_start_i      = 1'b0;
        bus.enemy_reserve_i    = '0;
        bus.enemy_die_i        = '0;
        bus.spawn_point_busy_i = '0;
`ifdef SPAWN_FREEZE_EN
        bus.freeze_i           = 1'b0;
`endif
        test_reset();
        test_fill();
        test_die_respawn();
        test_busy();
        test_clear();
        test_double_die();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
